// File: rtl/tri_st_or_reduce_pipe_if.sv
// Bus bundle for tri_st_or_reduce_pipe: active-low data beat in, registered OR flags out.
interface tri_st_or_reduce_pipe_if #(
    parameter int WIDTH = 64,
    parameter int SEG   = 2,
    parameter int SEG_W = 1
);
    logic [0:WIDTH-1] d_b;
    logic             d_vld;
    logic             acc_mode;
    logic             acc_clr;
    logic [0:SEG-1]   or_seg;
    logic             or_any;
    logic [0:SEG_W-1] first_seg;
    logic             out_vld;

    modport master (
        output d_b, d_vld, acc_mode, acc_clr,
        input  or_seg, or_any, first_seg, out_vld
    );

    modport slave (
        input  d_b, d_vld, acc_mode, acc_clr,
        output or_seg, or_any, first_seg, out_vld
    );
endinterface

// File: rtl/tri_st_or_reduce_pipe.sv
// Two-stage OR-reduce of an active-low word into per-segment flags, with sticky
// accumulate, whole-word OR and lowest-active-segment index.
module tri_st_or_reduce_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 2,
    parameter int SEG_W = 1
) (
    input  logic                   nclk,
    input  logic                   rst,
    tri_st_or_reduce_pipe_if.slave bus
);
    localparam int NGRP = WIDTH / 8;
    localparam int GPS  = NGRP / SEG;

    // NAND/NOR/NAND tree: active-low byte in, positive-logic "any bit asserted" out.
    function automatic logic grp_or(input logic [0:7] b);
        logic [0:3] pair_or;
        logic [0:1] quad_nor;
        for (int p = 0; p < 4; p++) begin
            pair_or[p] = ~(b[2*p] & b[2*p+1]);
        end
        quad_nor[0] = ~(pair_or[0] | pair_or[1]);
        quad_nor[1] = ~(pair_or[2] | pair_or[3]);
        return ~(quad_nor[0] & quad_nor[1]);
    endfunction

    function automatic logic [SEG_W-1:0] prio_enc(input logic [0:SEG-1] v);
        logic [SEG_W-1:0] idx;
        idx = '0;
        for (int k = SEG - 1; k >= 0; k--) begin
            if (v[k]) idx = SEG_W'(k);
        end
        return idx;
    endfunction

    logic [0:NGRP-1]  grp_p1_d, grp_p1_q;
    logic             vld_p1_d, vld_p1_q;
    logic [0:SEG-1]   seg_new;
    logic [0:SEG-1]   seg_p2_d, seg_p2_q;
    logic             any_p2_d, any_p2_q;
    logic [SEG_W-1:0] first_p2_d, first_p2_q;
    logic             vld_p2_d, vld_p2_q;

    // ---- stage 1: per-byte group OR, loaded only on a valid beat ----
    always_comb begin
        grp_p1_d = grp_p1_q;
        if (bus.d_vld) begin
            for (int g = 0; g < NGRP; g++) begin
                grp_p1_d[g] = grp_or(bus.d_b[8*g +: 8]);
            end
        end
        vld_p1_d = bus.d_vld;
    end

    // ---- stage 2: segment reduce, accumulate/clear, derived flags ----
    always_comb begin
        for (int k = 0; k < SEG; k++) begin
            seg_new[k] = |grp_p1_q[k*GPS +: GPS];
        end
        seg_p2_d = seg_p2_q;
        // A clear coinciding with a beat still keeps that beat's flags.
        if (bus.acc_clr) begin
            seg_p2_d = vld_p1_q ? seg_new : '0;
        end else if (vld_p1_q) begin
            seg_p2_d = bus.acc_mode ? (seg_p2_q | seg_new) : seg_new;
        end
        any_p2_d   = |seg_p2_d;
        first_p2_d = prio_enc(seg_p2_d);
        vld_p2_d   = vld_p1_q;
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            grp_p1_q   <= '0;
            vld_p1_q   <= 1'b0;
            seg_p2_q   <= '0;
            any_p2_q   <= 1'b0;
            first_p2_q <= '0;
            vld_p2_q   <= 1'b0;
        end else begin
            grp_p1_q   <= grp_p1_d;
            vld_p1_q   <= vld_p1_d;
            seg_p2_q   <= seg_p2_d;
            any_p2_q   <= any_p2_d;
            first_p2_q <= first_p2_d;
            vld_p2_q   <= vld_p2_d;
        end
    end

    assign bus.or_seg    = seg_p2_q;
    assign bus.or_any    = any_p2_q;
    assign bus.first_seg = first_p2_q;
    assign bus.out_vld   = vld_p2_q;
endmodule

// File: tb/tb_tri_st_or_reduce_pipe.sv
// Scoreboard bench: two instances (SEG=2, SEG=4) share stimulus; a set-based model
// predicts each beat's flags and a negedge monitor compares what the DUTs present.
`timescale 1ns/1ps
module tb_tri_st_or_reduce_pipe;
    localparam int W = 64;

    typedef struct packed {
        logic [3:0] seg;   // seg[k] = flag of segment k
        logic       any;
        logic [1:0] first;
    } res_t;

    logic nclk = 1'b0;
    logic rst  = 1'b1;
    always #5 nclk = ~nclk;

    tri_st_or_reduce_pipe_if #(.WIDTH(W), .SEG(2), .SEG_W(1)) bus2 ();
    tri_st_or_reduce_pipe_if #(.WIDTH(W), .SEG(4), .SEG_W(2)) bus4 ();

    tri_st_or_reduce_pipe #(.WIDTH(W), .SEG(2), .SEG_W(1)) dut2 (
        .nclk(nclk), .rst(rst), .bus(bus2));
    tri_st_or_reduce_pipe #(.WIDTH(W), .SEG(4), .SEG_W(2)) dut4 (
        .nclk(nclk), .rst(rst), .bus(bus4));

    res_t         q   [2][$];
    res_t         st  [2];
    res_t         vis [2];
    logic         upd      = 1'b0;
    logic         vis_vld  = 1'b0;
    logic         pend_vld = 1'b0;
    logic [0:W-1] pend_db  = '1;
    logic [0:W-1] ones     = '1;
    logic         cur_mode = 1'b0;
    bit           mon_on   = 1'b0;
    int           n_vec    = 0;
    int           n_bad    = 0;

    function automatic int segn(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic res_t mk(input logic [3:0] s);
        res_t r;
        r.seg   = s;
        r.any   = |s;
        r.first = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (s[k]) r.first = 2'(k);
        end
        return r;
    endfunction

    // Segment k is set when any data bit in its slice is driven low.
    function automatic res_t ref_seg(input logic [0:W-1] db, input int ns);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            if (db[i] == 1'b0) s[i / (W / ns)] = 1'b1;
        end
        return mk(s);
    endfunction

    function automatic logic [0:W-1] one_low(input int b);
        logic [0:W-1] d;
        d = '1;
        d[b] = 1'b0;
        return d;
    endfunction

    function automatic logic [0:W-1] rnd_db();
        logic [0:W-1] d;
        d = '1;
        case ($urandom_range(0, 3))
            0: d = '1;
            1: begin
                d[$urandom_range(0, W-1)] = 1'b0;
                if ($urandom_range(0, 1) == 1) d[$urandom_range(0, W-1)] = 1'b0;
            end
            2: d = {$urandom, $urandom};
            default: d[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
        endcase
        return d;
    endfunction

    function automatic res_t got_res(input int i);
        res_t r;
        r = '0;
        if (i == 0) begin
            for (int k = 0; k < 2; k++) r.seg[k] = bus2.or_seg[k];
            r.any   = bus2.or_any;
            r.first = {1'b0, bus2.first_seg};
        end else begin
            for (int k = 0; k < 4; k++) r.seg[k] = bus4.or_seg[k];
            r.any   = bus4.or_any;
            r.first = bus4.first_seg;
        end
        return r;
    endfunction

    function automatic logic got_vld(input int i);
        return (i == 0) ? bus2.out_vld : bus4.out_vld;
    endfunction

    // One clock of stimulus; the model applies the stage-2 update for the edge ending this cycle.
    task automatic step(input logic v, input logic [0:W-1] db, input logic mode, input logic clr);
        @(posedge nclk);
        #1;
        vis_vld = upd;
        for (int i = 0; i < 2; i++) vis[i] = st[i];
        bus2.d_vld = v; bus2.d_b = db; bus2.acc_mode = mode; bus2.acc_clr = clr;
        bus4.d_vld = v; bus4.d_b = db; bus4.acc_mode = mode; bus4.acc_clr = clr;
        if (rst) begin
            upd      = 1'b0;
            pend_vld = 1'b0;
            for (int i = 0; i < 2; i++) st[i] = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                res_t nw;
                nw = ref_seg(pend_db, segn(i));
                if (clr)           st[i] = pend_vld ? nw : mk(4'b0000);
                else if (pend_vld) st[i] = mode ? mk(st[i].seg | nw.seg) : nw;
                if (pend_vld) q[i].push_back(st[i]);
            end
            upd      = pend_vld;
            pend_vld = v;
            pend_db  = db;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, ones, cur_mode, 1'b0);
    endtask

    task automatic chk_const(input string nm, input int i, input logic [3:0] s, input logic ov);
        res_t g, e;
        e = mk(s);
        g = got_res(i);
        n_vec++;
        if (g !== e || got_vld(i) !== ov) begin
            n_bad++;
            $display("FAIL %s seg%0d: got seg=%b any=%b first=%0d vld=%b, want seg=%b any=%b first=%0d vld=%b",
                     nm, segn(i), g.seg, g.any, g.first, got_vld(i), e.seg, e.any, e.first, ov);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            res_t g;
            g = got_res(i);
            n_vec++;
            if (g !== '0 || got_vld(i) !== 1'b0) begin
                n_bad++;
                $display("FAIL %s seg%0d: got seg=%b any=%b first=%0d vld=%b, want all zero",
                         nm, segn(i), g.seg, g.any, g.first, got_vld(i));
            end
        end
    endtask

    task automatic mon_one(input int i);
        res_t g, e;
        logic ov;
        g  = got_res(i);
        ov = got_vld(i);
        n_vec++;
        if (ov !== vis_vld) begin
            n_bad++;
            $display("FAIL out_vld seg%0d at %0t: got %b want %b", segn(i), $time, ov, vis_vld);
        end
        if (ov === 1'b1) begin
            if (q[i].size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat seg%0d at %0t: got out_vld=1 want no beat", segn(i), $time);
            end else begin
                e = q[i].pop_front();
                n_vec++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL beat seg%0d at %0t: got seg=%b any=%b first=%0d want seg=%b any=%b first=%0d",
                             segn(i), $time, g.seg, g.any, g.first, e.seg, e.any, e.first);
                end
            end
        end else begin
            n_vec++;
            if (g !== vis[i]) begin
                n_bad++;
                $display("FAIL hold seg%0d at %0t: got seg=%b any=%b first=%0d want seg=%b any=%b first=%0d",
                         segn(i), $time, g.seg, g.any, g.first, vis[i].seg, vis[i].any, vis[i].first);
            end
        end
    endtask

    always @(negedge nclk) begin
        if (mon_on && !rst) begin
            for (int i = 0; i < 2; i++) mon_one(i);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:W-1] db;
        res_t         r;
        bus2.d_b = '1; bus2.d_vld = 1'b0; bus2.acc_mode = 1'b0; bus2.acc_clr = 1'b0;
        bus4.d_b = '1; bus4.d_vld = 1'b0; bus4.acc_mode = 1'b0; bus4.acc_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i]  = '0;
            vis[i] = '0;
        end
        mon_on = 1'b1;

        repeat (3) step(1'b0, ones, 1'b0, 1'b0);
        chk_zero("reset_state");
        rst = 1'b0;

        // Single beat with no active bits.
        step(1'b1, ones, 1'b0, 1'b0);
        idle(2);
        chk_const("all_ones", 0, 4'b0000, 1'b1);
        chk_const("all_ones", 1, 4'b0000, 1'b1);

        // Back-to-back single-bit beats, load mode.
        step(1'b1, one_low(40), 1'b0, 1'b0);
        step(1'b1, one_low(3), 1'b0, 1'b0);
        idle(1);
        chk_const("bit40", 0, 4'b0010, 1'b1);
        chk_const("bit40", 1, 4'b0100, 1'b1);
        idle(1);
        chk_const("bit3", 0, 4'b0001, 1'b1);
        chk_const("bit3", 1, 4'b0001, 1'b1);

        // Sticky accumulate from a cleared state.
        cur_mode = 1'b1;
        step(1'b0, ones, 1'b1, 1'b1);
        step(1'b1, one_low(63), 1'b1, 1'b0);
        step(1'b1, one_low(20), 1'b1, 1'b0);
        idle(1);
        chk_const("acc_bit63", 1, 4'b1000, 1'b1);
        chk_const("acc_bit63", 0, 4'b0010, 1'b1);
        idle(1);
        chk_const("acc_bit20", 1, 4'b1010, 1'b1);
        chk_const("acc_bit20", 0, 4'b0011, 1'b1);

        // Clear coinciding with a beat in stage 1, then clear alone.
        step(1'b1, one_low(0), 1'b1, 1'b0);
        step(1'b0, ones, 1'b1, 1'b1);
        idle(1);
        chk_const("clr_with_beat", 1, 4'b0001, 1'b1);
        chk_const("clr_with_beat", 0, 4'b0001, 1'b1);
        step(1'b0, ones, 1'b1, 1'b1);
        idle(1);
        chk_const("clr_alone", 1, 4'b0000, 1'b0);
        chk_const("clr_alone", 0, 4'b0000, 1'b0);

        // Streaming, load mode.
        cur_mode = 1'b0;
        for (int n = 0; n < 8; n++) step(1'b1, rnd_db(), 1'b0, 1'b0);
        idle(3);

        // Async reset with two beats in flight.
        step(1'b1, one_low(5), 1'b0, 1'b0);
        step(1'b1, one_low(50), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            st[i] = '0;
        end
        pend_vld = 1'b0;
        upd      = 1'b0;
        #1;
        chk_zero("async_reset");
        step(1'b0, ones, 1'b0, 1'b0);
        step(1'b0, ones, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        db = one_low(17);
        step(1'b1, db, 1'b0, 1'b0);
        idle(2);
        r = ref_seg(db, 2);
        chk_const("post_reset", 0, r.seg, 1'b1);
        r = ref_seg(db, 4);
        chk_const("post_reset", 1, r.seg, 1'b1);

        // Random mix of beats, modes and clears.
        for (int n = 0; n < 300; n++) begin
            logic v, m, c;
            v = ($urandom_range(0, 9) < 7);
            m = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0);
            cur_mode = m;
            step(v, rnd_db(), m, c);
        end
        cur_mode = 1'b0;
        idle(4);
        mon_on = 1'b0;

        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q[i].size() != 0) begin
                n_bad++;
                $display("FAIL drain seg%0d: got %0d beats outstanding want 0", segn(i), q[i].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
